estimador_ctrl: RTL
===================

ESTIMADOR_CTRL -- requirements
Module: estimador_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 1000: sample period in clk cycles (minimum 8).
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles allowed per estimator wait state.
REQ-003 SHALL have port clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  enables periodic sampling.
REQ-006 SHALL have port sample_i, sample_v  input  32 each  current and voltage samples from the acquisition front end.
REQ-007 SHALL have port est_start  output  1  start request to the estimator.
REQ-008 SHALL have port est_ack  input  1  estimator acknowledge; idle-high, low while busy.
REQ-009 SHALL have port est_I, est_V  output  32 each  operands presented to the estimator.
REQ-010 SHALL have port est_result_i, est_result_v  input  32 each  estimator results.
REQ-011 SHALL have port out_i, out_v  output  32 each  last completed results.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when out_i/out_v update.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have port overrun_cnt  output  8  count of dropped ticks.
REQ-015 SHALL have port timeout_err  output  1  sticky estimator-timeout flag.
REQ-016 SHALL have port clr_err  input  1  synchronous clear of timeout_err and overrun_cnt.

Function
REQ-017 Period counter SHALL count 0..PERIOD-1 while enable=1, wrap to 0, and assert internal tick for one cycle at PERIOD-1; enable=0 SHALL hold it at 0 with no ticks.
REQ-018 FSM states SHALL be IDLE, START, WAIT_LO, WAIT_HI; all outputs registered.
REQ-019 IDLE: on tick, SHALL latch sample_i/sample_v into est_I/est_V and go to START.
REQ-020 START: est_start SHALL be 1 for exactly one cycle, then go to WAIT_LO; est_start SHALL be 0 in every other state.
REQ-021 WAIT_LO: SHALL stay until est_ack=0 is sampled, then go to WAIT_HI.
REQ-022 WAIT_HI: on est_ack=1, SHALL load est_result_i/v into out_i/out_v, pulse out_valid the next cycle, and return to IDLE.
REQ-023 est_I/est_V SHALL stay stable from the IDLE->START edge until IDLE is re-entered.
REQ-024 Wait counter SHALL clear on entry to WAIT_LO and to WAIT_HI; if either state remains TIMEOUT cycles without its exit condition, SHALL set timeout_err, go to IDLE, leave out_i/out_v unchanged, and not pulse out_valid.
REQ-025 A tick while not in IDLE SHALL drop that sample and increment overrun_cnt, saturating at 255.
REQ-026 clr_err=1 SHALL clear timeout_err and overrun_cnt; if a set or increment occurs in the same cycle, the set/increment SHALL win (timeout_err=1, overrun_cnt=1).
REQ-027 enable falling mid-transaction SHALL NOT abort it; the transaction completes normally, then no new ticks occur.
REQ-028 A tick arriving in the same cycle the FSM returns to IDLE SHALL count as an overrun, because the FSM is not yet in IDLE.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, period and wait counters to 0, and est_start, out_valid, timeout_err and busy to 0.
REQ-030 reset_n=0 SHALL asynchronously force est_I, est_V, out_i, out_v and overrun_cnt to 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no out_valid pulse; operation SHALL resume from counter 0 after release.

Verification
REQ-032 PERIOD=8, sample_i=0x10, sample_v=0x20, estimator model echoing operands with ack low for 1 cycle -> est_start pulse every 8 cycles, out_i=0x10, out_v=0x20, one out_valid per period.
REQ-033 Estimator holding est_ack=1 forever, TIMEOUT=64 -> timeout_err=1 exactly 64 cycles after entry to WAIT_LO, no out_valid, busy=0 next cycle.
REQ-034 Estimator holding ack low for 20 cycles with PERIOD=8 -> 2 ticks during WAIT_HI, overrun_cnt=2, result still captured.
REQ-035 clr_err pulsed in the same cycle as an overrun tick with overrun_cnt=5 -> overrun_cnt=1.
REQ-036 reset_n pulsed low during WAIT_HI -> all outputs 0 immediately, no out_valid, first est_start exactly PERIOD cycles after release.
REQ-037 enable dropped in WAIT_LO -> transaction completes with one out_valid, then no est_start for 3*PERIOD cycles.

Source files
------------

// File: rtl/estimador_ctrl.sv
// estimador_ctrl: periodic sample sequencer for an external estimator.
//
// Every PERIOD cycles (while enable=1) the current/voltage samples are
// latched onto est_I/est_V and handed to the estimator with a one-cycle
// est_start. The estimator's acknowledge sits high when idle, drops while
// it works and rises again once est_result_i/v are valid. The results then
// land in out_i/out_v together with a one-cycle out_valid.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   enable                        run the sample-period counter
//   sample_i, sample_v            acquisition front-end samples
//   est_start, est_ack            estimator handshake
//   est_I, est_V                  operands held for the estimator
//   est_result_i, est_result_v    estimator results
//   out_i, out_v, out_valid       last completed results and update strobe
//   busy                          a transaction is in flight
//   overrun_cnt                   ticks dropped because busy (saturating)
//   timeout_err, clr_err          sticky wait timeout flag and its clear
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the next period tick
// START   | est_start asserted for this single cycle
// WAIT_LO | waiting for the estimator to drop est_ack (accepted)
// WAIT_HI | waiting for est_ack to rise again (results valid)
module estimador_ctrl #(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] sample_i,
    input  logic [31:0] sample_v,
    output logic        est_start,
    input  logic        est_ack,
    output logic [31:0] est_I,
    output logic [31:0] est_V,
    input  logic [31:0] est_result_i,
    input  logic [31:0] est_result_v,
    output logic [31:0] out_i,
    output logic [31:0] out_v,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err,
    input  logic        clr_err
);

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;
    localparam logic [1:0] WAIT_HI = 2'd3;

    logic [PW-1:0] period_cnt;
    logic [TW-1:0] wait_cnt;
    logic [1:0]    state;
    logic          tick;
    logic          wait_expired;
    logic          overrun;
    logic          to_set;

    assign tick         = enable && (period_cnt == PER_LAST);
    assign wait_expired = (wait_cnt == WAIT_LAST);
    // A tick is dropped whenever the registered state is not IDLE, which
    // includes the final WAIT_HI cycle that is about to return to IDLE.
    assign overrun      = tick && (state != IDLE);
    assign to_set       = wait_expired &&
                          (((state == WAIT_LO) && est_ack) ||
                           ((state == WAIT_HI) && !est_ack));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (!enable) begin
            period_cnt <= '0;
        end else if (period_cnt == PER_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            est_start <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            est_I     <= '0;
            est_V     <= '0;
            out_i     <= '0;
            out_v     <= '0;
        end else begin
            est_start <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        est_I     <= sample_i;
                        est_V     <= sample_v;
                        est_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!est_ack) begin
                        wait_cnt <= '0;
                        state    <= WAIT_HI;
                    end else if (wait_expired) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (est_ack) begin
                        out_i     <= est_result_i;
                        out_v     <= est_result_v;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_expired) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A new error event in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else if (clr_err) begin
            timeout_err <= to_set;
            overrun_cnt <= overrun ? 8'd1 : 8'd0;
        end else begin
            if (to_set) begin
                timeout_err <= 1'b1;
            end
            if (overrun && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule
